video_layer_mixer: RTL and testbench
====================================

Name: video_layer_mixer

Overview:
- Parametrised N-layer pixel compositor for the HDMI overlay video path.
- Sits between the demo pattern generators (stars, raster bars, future sprites) and the video output encoder.
- Per layer: colour-key transparency, per-layer enable, optional additive blend.
- Registered pipeline; delays the sync/enable controls to stay aligned with pixel data.
- Config is double-buffered and applied only at frame start, so changes never tear mid-frame.

Parameters:
- NLAYERS, 4: number of input layers; layer 0 is bottom, layer NLAYERS-1 is top; range 2..8.
- COLSPC, 10: colour component width in bits.
- LATENCY, 2: fixed pipeline depth in cycles; only the value 2 is supported; elaboration error otherwise.

Ports:
- video_clk_pix  in  1  pixel clock; only clock.
- video_rst  in  1  synchronous, active-high reset.
- video_enable  in  1  active-video flag for the current pixel.
- hsync  in  1  horizontal sync for the current pixel.
- vsync  in  1  vertical sync for the current pixel.
- frame_start  in  1  one-cycle pulse at the first pixel of a frame.
- layer_red  in  NLAYERS*COLSPC  packed red; layer i at bits [i*COLSPC +: COLSPC].
- layer_green  in  NLAYERS*COLSPC  packed green; same packing.
- layer_blue  in  NLAYERS*COLSPC  packed blue; same packing.
- cfg_layer_en  in  NLAYERS  staged per-layer enable.
- cfg_add_mode  in  NLAYERS  staged per-layer additive mode (ignored unless MIXER_ADD_MODE_EN).
- cfg_key_red  in  COLSPC  staged transparency key, red.
- cfg_key_green  in  COLSPC  staged transparency key, green.
- cfg_key_blue  in  COLSPC  staged transparency key, blue.
- out_enable  out  1  video_enable delayed LATENCY cycles.
- out_hsync  out  1  hsync delayed LATENCY cycles.
- out_vsync  out  1  vsync delayed LATENCY cycles.
- red  out  COLSPC  composited red.
- green  out  COLSPC  composited green.
- blue  out  COLSPC  composited blue.

Behaviour:
- Reset, synchronous on video_rst high, takes priority over everything:
  - all outputs 0, pipeline flushed to 0;
  - active config: layer_en all ones, add_mode all zeros, key = 0/0/0.
- Config shadowing:
  - cfg_* inputs are sampled into the active config only on a cycle where frame_start=1 and video_rst=0.
  - The frame_start pixel and all later pixels use the new config.
  - The pixel on the frame_start cycle uses the new config, via a bypass mux into stage 1.
  - cfg_* changes at any other time have no effect.
- Stage 1, registered:
  - Per layer i: opaque_i = active_en[i] AND (colour != active key). Equality requires all three components to match.
  - Colours, opaque flags and video_enable/hsync/vsync are registered.
- Stage 2, registered:
  - Priority selection: the highest-index opaque layer wins.
  - No opaque layer: output 0/0/0.
  - Registered stage-1 video_enable low: output 0/0/0, regardless of layers.
  - Syncs and enable are forwarded unchanged.
- Latency: exactly 2 cycles from input pixel to red/green/blue and the out_* controls.
- Simultaneous events:
  - frame_start together with video_rst: reset wins, config returns to reset defaults.
  - Reset mid-frame: outputs are 0 on the next edge; normal output resumes 2 cycles after reset deasserts.
- Width: all comparisons and selects are at COLSPC bits; no truncation in the priority path.

Optional Feature:
- Macro: MIXER_ADD_MODE_EN.
- Defined:
  - Stage 2 composites bottom-up.
  - An opaque layer with active add_mode[i]=1 adds its components to the accumulated result of the layers below.
  - Addition is per component and saturates at 2^COLSPC-1.
  - An opaque layer with add_mode=0 replaces the accumulator.
  - Transparent layers leave the accumulator unchanged.
  - The accumulator starts at 0.
- Undefined:
  - cfg_add_mode is ignored and its shadow register is not built.
  - Pure priority selection applies.
  - Latency stays 2 in both builds.

Test Plan:
- Priority, NLAYERS=4, COLSPC=10, key 0:
  - Stimulus: layer0=100/0/0, layer2=0/200/0, layers 1 and 3 = 0/0/0, video_enable=1.
  - Required: red/green/blue = 0/200/0 two cycles later.
- Transparency and enables:
  - Stimulus: all layers 0/0/0.
  - Required: output 0/0/0.
  - Then disable layer 2 at frame_start with layer0=100/0/0, layer2=0/200/0.
  - Required: output 100/0/0 from that frame's first pixel.
- Config shadowing:
  - Stimulus: change cfg_key to 0/200/0 mid-frame.
  - Required: output unchanged until the next frame_start; from that frame's first pixel, layer2=0/200/0 is treated as transparent.
- Sync alignment:
  - Stimulus: random hsync/vsync/video_enable patterns.
  - Required: out_* equal inputs delayed exactly 2 cycles.
  - Required: colour is 0 whenever out_enable=0.
- Reset:
  - Stimulus: assert video_rst mid-line.
  - Required: all outputs 0 next cycle; active key back to 0/0/0; valid pixels 2 cycles after release.
- Additive mode (MIXER_ADD_MODE_EN):
  - Stimulus: layer0=900/10/0, layer1=200/20/0 with add_mode[1]=1.
  - Required: output 1023/30/0 (red saturates).

Source files
------------

// File: rtl/video_layer_mixer.sv
// rtl/video_layer_mixer.sv - N-layer colour-keyed pixel compositor with a fixed 2-cycle pipeline
// Additive blending is built only when MIXER_ADD_MODE_EN is defined.
module video_layer_mixer #(
  parameter int NLAYERS = 4,
  parameter int COLSPC  = 10,
  parameter int LATENCY = 2
) (
  input  logic                        video_clk_pix,
  input  logic                        video_rst,
  input  logic                        video_enable,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic                        frame_start,
  input  logic [NLAYERS*COLSPC-1:0]   layer_red,
  input  logic [NLAYERS*COLSPC-1:0]   layer_green,
  input  logic [NLAYERS*COLSPC-1:0]   layer_blue,
  input  logic [NLAYERS-1:0]          cfg_layer_en,
  input  logic [NLAYERS-1:0]          cfg_add_mode,
  input  logic [COLSPC-1:0]           cfg_key_red,
  input  logic [COLSPC-1:0]           cfg_key_green,
  input  logic [COLSPC-1:0]           cfg_key_blue,
  output logic                        out_enable,
  output logic                        out_hsync,
  output logic                        out_vsync,
  output logic [COLSPC-1:0]           red,
  output logic [COLSPC-1:0]           green,
  output logic [COLSPC-1:0]           blue
);

  localparam int W = NLAYERS * COLSPC;

  if (LATENCY != 2) begin : g_bad_latency
    $error("video_layer_mixer: only LATENCY=2 is supported");
  end
  if (NLAYERS < 2 || NLAYERS > 8) begin : g_bad_nlayers
    $error("video_layer_mixer: NLAYERS must be in 2..8");
  end

  logic [NLAYERS-1:0] act_en_q;
  logic [COLSPC-1:0]  act_key_r_q, act_key_g_q, act_key_b_q;
  logic [NLAYERS-1:0] use_en;
  logic [COLSPC-1:0]  use_key_r, use_key_g, use_key_b;

  // The frame_start pixel already sees the newly staged config.
  assign use_en    = frame_start ? cfg_layer_en  : act_en_q;
  assign use_key_r = frame_start ? cfg_key_red   : act_key_r_q;
  assign use_key_g = frame_start ? cfg_key_green : act_key_g_q;
  assign use_key_b = frame_start ? cfg_key_blue  : act_key_b_q;

  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      act_en_q    <= '1;
      act_key_r_q <= '0;
      act_key_g_q <= '0;
      act_key_b_q <= '0;
    end else if (frame_start) begin
      act_en_q    <= cfg_layer_en;
      act_key_r_q <= cfg_key_red;
      act_key_g_q <= cfg_key_green;
      act_key_b_q <= cfg_key_blue;
    end
  end

`ifdef MIXER_ADD_MODE_EN
  logic [NLAYERS-1:0] act_add_q, use_add, s1_add_q;

  assign use_add = frame_start ? cfg_add_mode : act_add_q;

  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      act_add_q <= '0;
      s1_add_q  <= '0;
    end else begin
      if (frame_start) act_add_q <= cfg_add_mode;
      s1_add_q <= use_add;
    end
  end

  function automatic logic [COLSPC-1:0] sat_add(input logic [COLSPC-1:0] a,
                                                input logic [COLSPC-1:0] b);
    logic [COLSPC:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COLSPC] ? {COLSPC{1'b1}} : s[COLSPC-1:0];
  endfunction
`else
  logic unused_add_mode;
  assign unused_add_mode = ^cfg_add_mode;
`endif

  logic [NLAYERS-1:0] opaque_d;

  always_comb begin
    opaque_d = '0;
    for (int i = 0; i < NLAYERS; i++) begin
      opaque_d[i] = use_en[i] &&
                    !((layer_red[i*COLSPC +: COLSPC]   == use_key_r) &&
                      (layer_green[i*COLSPC +: COLSPC] == use_key_g) &&
                      (layer_blue[i*COLSPC +: COLSPC]  == use_key_b));
    end
  end

  logic [W-1:0]       s1_r_q, s1_g_q, s1_b_q;
  logic [NLAYERS-1:0] s1_opaque_q;
  logic               s1_en_q, s1_hs_q, s1_vs_q;

  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      s1_r_q      <= '0;
      s1_g_q      <= '0;
      s1_b_q      <= '0;
      s1_opaque_q <= '0;
      s1_en_q     <= 1'b0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
    end else begin
      s1_r_q      <= layer_red;
      s1_g_q      <= layer_green;
      s1_b_q      <= layer_blue;
      s1_opaque_q <= opaque_d;
      s1_en_q     <= video_enable;
      s1_hs_q     <= hsync;
      s1_vs_q     <= vsync;
    end
  end

  logic [COLSPC-1:0] mix_r_d, mix_g_d, mix_b_d;

  // Bottom-up walk: a later opaque layer overrides, so the top opaque layer wins.
  always_comb begin
    mix_r_d = '0;
    mix_g_d = '0;
    mix_b_d = '0;
    for (int i = 0; i < NLAYERS; i++) begin
      if (s1_opaque_q[i]) begin
`ifdef MIXER_ADD_MODE_EN
        if (s1_add_q[i]) begin
          mix_r_d = sat_add(mix_r_d, s1_r_q[i*COLSPC +: COLSPC]);
          mix_g_d = sat_add(mix_g_d, s1_g_q[i*COLSPC +: COLSPC]);
          mix_b_d = sat_add(mix_b_d, s1_b_q[i*COLSPC +: COLSPC]);
        end else
`endif
        begin
          mix_r_d = s1_r_q[i*COLSPC +: COLSPC];
          mix_g_d = s1_g_q[i*COLSPC +: COLSPC];
          mix_b_d = s1_b_q[i*COLSPC +: COLSPC];
        end
      end
    end
    if (!s1_en_q) begin
      mix_r_d = '0;
      mix_g_d = '0;
      mix_b_d = '0;
    end
  end

  logic              out_en_q, out_hs_q, out_vs_q;
  logic [COLSPC-1:0] red_q, green_q, blue_q;

  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      out_en_q <= 1'b0;
      out_hs_q <= 1'b0;
      out_vs_q <= 1'b0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
    end else begin
      out_en_q <= s1_en_q;
      out_hs_q <= s1_hs_q;
      out_vs_q <= s1_vs_q;
      red_q    <= mix_r_d;
      green_q  <= mix_g_d;
      blue_q   <= mix_b_d;
    end
  end

  assign out_enable = out_en_q;
  assign out_hsync  = out_hs_q;
  assign out_vsync  = out_vs_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;

endmodule

// File: tb/tb_video_layer_mixer.sv
// tb/tb_video_layer_mixer.sv - randomized and directed checks of video_layer_mixer against a reference model
module tb_video_layer_mixer;
  localparam int NL = 4;
  localparam int CW = 10;
`ifdef MIXER_ADD_MODE_EN
  localparam logic [NL-1:0] ADD_MASK = '1;
`else
  localparam logic [NL-1:0] ADD_MASK = '0;
`endif

  logic clk, rst, ve, hs, vs, fs;
  logic [NL*CW-1:0] lr, lg, lb;
  logic [NL-1:0] cfg_en, cfg_add;
  logic [CW-1:0] kr, kg, kb;
  logic o_en, o_hs, o_vs;
  logic [CW-1:0] o_r, o_g, o_b;

  video_layer_mixer #(.NLAYERS(NL), .COLSPC(CW), .LATENCY(2)) dut (
    .video_clk_pix(clk), .video_rst(rst), .video_enable(ve), .hsync(hs), .vsync(vs),
    .frame_start(fs), .layer_red(lr), .layer_green(lg), .layer_blue(lb),
    .cfg_layer_en(cfg_en), .cfg_add_mode(cfg_add),
    .cfg_key_red(kr), .cfg_key_green(kg), .cfg_key_blue(kb),
    .out_enable(o_en), .out_hsync(o_hs), .out_vsync(o_vs),
    .red(o_r), .green(o_g), .blue(o_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Composite one pixel straight from the rules: walk layers bottom to top.
  function automatic logic [3*CW-1:0] mix(input logic [NL*CW-1:0] r, g, b,
                                          input logic [NL-1:0] en, add,
                                          input logic [CW-1:0] k_r, k_g, k_b,
                                          input logic v);
    int ar, ag, ab, cr, cg, cb;
    int maxv;
    maxv = (1 << CW) - 1;
    ar = 0; ag = 0; ab = 0;
    if (!v) return '0;
    for (int i = 0; i < NL; i++) begin
      cr = int'(r[i*CW +: CW]); cg = int'(g[i*CW +: CW]); cb = int'(b[i*CW +: CW]);
      if (en[i] && !(cr == int'(k_r) && cg == int'(k_g) && cb == int'(k_b))) begin
        if (add[i]) begin
          ar = (ar + cr > maxv) ? maxv : ar + cr;
          ag = (ag + cg > maxv) ? maxv : ag + cg;
          ab = (ab + cb > maxv) ? maxv : ab + cb;
        end else begin
          ar = cr; ag = cg; ab = cb;
        end
      end
    end
    return {CW'(ar), CW'(ag), CW'(ab)};
  endfunction

  logic [NL-1:0] m_en, m_add, eff_en, eff_add;
  logic [CW-1:0] m_kr, m_kg, m_kb, eff_kr, eff_kg, eff_kb;
  logic [3*CW-1:0] res, p_rgb, e_rgb;
  logic p_en, p_hs, p_vs, e_en, e_hs, e_vs;
  logic chk_on = 1'b0;

  assign eff_en  = fs ? cfg_en : m_en;
  assign eff_add = (fs ? cfg_add : m_add) & ADD_MASK;
  assign eff_kr  = fs ? kr : m_kr;
  assign eff_kg  = fs ? kg : m_kg;
  assign eff_kb  = fs ? kb : m_kb;
  assign res     = mix(lr, lg, lb, eff_en, eff_add, eff_kr, eff_kg, eff_kb, ve);

  // p_* holds the pixel seen one edge ago, e_* what the outputs must show now.
  always @(posedge clk) begin
    if (rst) begin
      m_en <= '1; m_add <= '0; m_kr <= '0; m_kg <= '0; m_kb <= '0;
      p_en <= 1'b0; p_hs <= 1'b0; p_vs <= 1'b0; p_rgb <= '0;
      e_en <= 1'b0; e_hs <= 1'b0; e_vs <= 1'b0; e_rgb <= '0;
      chk_on <= 1'b1;
    end else begin
      e_en <= p_en; e_hs <= p_hs; e_vs <= p_vs; e_rgb <= p_rgb;
      p_en <= ve; p_hs <= hs; p_vs <= vs; p_rgb <= res;
      if (fs) begin
        m_en <= cfg_en; m_add <= cfg_add; m_kr <= kr; m_kg <= kg; m_kb <= kb;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("out_enable", 32'(o_en), 32'(e_en));
      cmp("out_hsync", 32'(o_hs), 32'(e_hs));
      cmp("out_vsync", 32'(o_vs), 32'(e_vs));
      cmp("red", 32'(o_r), 32'(e_rgb[3*CW-1:2*CW]));
      cmp("green", 32'(o_g), 32'(e_rgb[2*CW-1:CW]));
      cmp("blue", 32'(o_b), 32'(e_rgb[CW-1:0]));
      if (!o_en) cmp("blank_colour", 32'({o_r, o_g, o_b}), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_layer(input int i, input int r, input int g, input int b);
    lr[i*CW +: CW] = CW'(r);
    lg[i*CW +: CW] = CW'(g);
    lb[i*CW +: CW] = CW'(b);
  endtask

  task automatic lit(input string name, input int r, input int g, input int b);
    cmp({name, "_red"}, 32'(o_r), 32'(r));
    cmp({name, "_green"}, 32'(o_g), 32'(g));
    cmp({name, "_blue"}, 32'(o_b), 32'(b));
  endtask

  function automatic int rndc();
    return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1023));
  endfunction

  initial begin
    rst = 1'b1; ve = 1'b0; hs = 1'b0; vs = 1'b0; fs = 1'b0;
    lr = '0; lg = '0; lb = '0;
    cfg_en = '1; cfg_add = '0; kr = '0; kg = '0; kb = '0;
    step(); step(); step();
    rst = 1'b0; ve = 1'b1;

    set_layer(0, 100, 0, 0); set_layer(2, 0, 200, 0);
    step(); step(); lit("priority", 0, 200, 0);

    lr = '0; lg = '0; lb = '0;
    step(); step(); lit("all_transparent", 0, 0, 0);

    set_layer(0, 100, 0, 0); set_layer(2, 0, 200, 0);
    cfg_en = 4'b1011;
    step(); step(); lit("en_staged", 0, 200, 0);
    fs = 1'b1; step(); fs = 1'b0; step(); lit("en_frame_start", 100, 0, 0);

    cfg_en = '1;
    fs = 1'b1; step(); fs = 1'b0; step(); lit("en_restored", 0, 200, 0);

    set_layer(1, 0, 200, 0); set_layer(3, 0, 200, 0);
    kr = 10'd0; kg = 10'd200; kb = 10'd0;
    step(); step(); lit("key_staged", 0, 200, 0);
    fs = 1'b1; step(); fs = 1'b0; step(); lit("key_frame_start", 100, 0, 0);

    rst = 1'b1; step();
    lit("reset_out", 0, 0, 0);
    cmp("reset_out_enable", 32'(o_en), 32'd0);
    rst = 1'b0; step(); lit("reset_flush", 0, 0, 0);
    step(); lit("reset_key_default", 0, 200, 0);

    lr = '0; lg = '0; lb = '0;
    set_layer(0, 900, 10, 0); set_layer(1, 200, 20, 0);
    kr = '0; kg = '0; kb = '0; cfg_add = 4'b0010;
    fs = 1'b1; step(); fs = 1'b0; step();
`ifdef MIXER_ADD_MODE_EN
    lit("add_saturate", 1023, 30, 0);
`else
    lit("add_ignored", 200, 20, 0);
`endif

    for (int c = 0; c < 3000; c++) begin
      ve  = ($urandom_range(0, 3) != 0);
      hs  = 1'($urandom);
      vs  = 1'($urandom);
      fs  = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) begin
        cfg_en  = NL'($urandom);
        cfg_add = NL'($urandom);
        kr = CW'($urandom_range(0, 3));
        kg = CW'($urandom_range(0, 3));
        kb = CW'($urandom_range(0, 3));
      end
      for (int i = 0; i < NL; i++) begin
        if ($urandom_range(0, 3) == 0) set_layer(i, int'(kr), int'(kg), int'(kb));
        else set_layer(i, rndc(), rndc(), rndc());
      end
      step();
    end

    rst = 1'b0; fs = 1'b0;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
